l1_cache_responder: RTL and testbench
=====================================

Name: l1_cache_responder

Overview:
Direct-mapped, write-back, write-allocate L1 cache that serves the pipeline's icache/dcache request port: read/write, byte enables, word address, resp. It sits between the datapath's cache port and the 256-bit line-granular physical memory port. One instance is used as the icache and one as the dcache. Responds combinationally on hit; a miss runs an optional writeback followed by a line fill.

Parameters:
S_INDEX, 3, log2 of set count (8 sets); tag width = 32 - 5 - S_INDEX.
LINE_W, 256, line width in bits (32 bytes, offset = address[4:0]); fixed, no other values supported.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
mem_read  input  1  CPU read request, held until mem_resp
mem_write  input  1  CPU write request, held until mem_resp
mem_byte_enable  input  4  byte lanes for write
mem_address  input  32  CPU byte address; [1:0] ignored
mem_wdata  input  32  CPU write data
mem_rdata  output  32  read word, valid while mem_resp=1
mem_resp  output  1  request complete this cycle
pmem_read  output  1  line fill request
pmem_write  output  1  line writeback request
pmem_address  output  32  line address, [4:0]=0
pmem_wdata  output  256  evicted line
pmem_rdata  input  256  fill data, valid with pmem_resp
pmem_resp  input  1  physical memory transaction done

Behaviour:
- Storage per set: valid, dirty, tag, 256-bit line; all flops. Reset clears every valid and dirty bit. Tags and data are not reset.
- index = mem_address[S_INDEX+4:5]; word = mem_address[4:2]; hit = valid[index] && tag[index]==mem_address[31:S_INDEX+5].
- FSM states: IDLE, WRITEBACK, ALLOCATE. Reset state is IDLE. While rst=0 all outputs are 0.
- IDLE, no request: all outputs 0.
- IDLE, read hit: mem_resp=1 in the same cycle. mem_rdata = line[word].
- IDLE, write hit: mem_resp=1 in the same cycle. On the clock edge, bytes with mem_byte_enable[i]=1 are merged into line[word] byte i, and dirty is set. If mem_byte_enable==0, resp is still given, but the line and dirty bit are unchanged.
- Write hit, mem_rdata: carries the pre-write word. The CPU ignores it.
- mem_read and mem_write both high: treated as a write.
- IDLE miss, line valid and dirty: go to WRITEBACK. Otherwise go to ALLOCATE. mem_resp=0.
- WRITEBACK: pmem_write=1; pmem_address={stored tag, index, 5'b0}; pmem_wdata=stored line. Outputs are held stable until pmem_resp. On pmem_resp, clear dirty and go to ALLOCATE.
- ALLOCATE: pmem_read=1; pmem_address={mem_address[31:5], 5'b0}. On pmem_resp, load the line with pmem_rdata, set tag, valid=1, dirty=0, and return to IDLE.
- After a fill, the request is re-evaluated in IDLE as a hit. Miss latency = writeback cycles + fill cycles + 1.
- pmem_read and pmem_write are never high together.
- Request held across miss: the CPU keeps the address stable. If the request drops mid-miss, the transaction still completes and no mem_resp is issued.
- Back-to-back requests: mem_read may stay high continuously (icache use). Each cycle in IDLE is evaluated independently against the current address. There is no resp-to-request bubble.
- Reset asserted mid-WRITEBACK or mid-ALLOCATE: the transaction is abandoned immediately and pmem_* drop to 0 asynchronously. The partially filled line is discarded and valid stays 0.
- pmem_resp outside WRITEBACK or ALLOCATE is ignored.

Test Plan:
- Reset: rst=0 with arbitrary inputs -> all outputs 0; after rst=1, a read of 0x0000_0040 misses (pmem_read=1, pmem_address=0x0000_0040).
- Cold read miss then hit: read 0x0000_0044, fill with word1=0xDEADBEEF, pmem_resp after 5 cycles -> mem_resp one cycle after pmem_resp with mem_rdata=0xDEADBEEF. An immediate read of 0x0000_0048 gives mem_resp in the same cycle.
- Byte-enable write hit: after the line fill, write 0x0000_0044, be=4'b0101, wdata=0x11223344 -> same-cycle resp. A subsequent read returns 0xDE22BE44 and set 2 becomes dirty.
- Dirty conflict eviction: with the set-2 line dirty, read 0x0000_0140 -> pmem_write=1, pmem_address=0x0000_0040, pmem_wdata word1=0xDE22BE44. After pmem_resp, pmem_read=1 with pmem_address=0x0000_0140, then resp on the filled data.
- Continuous icache reads: mem_read held high, address stepping 0x40, 0x44, 0x48 each cycle on a resident line -> mem_resp=1 every cycle with the correct words.
- Reset mid-fill: assert rst during ALLOCATE, then pulse pmem_resp -> pmem_read=0 immediately. After release, a read of the same address misses again.

Source files
------------

// File: rtl/l1_cache_responder.sv
// l1_cache_responder: direct-mapped, write-back, write-allocate L1 cache.
// Hits respond combinationally; a miss runs an optional dirty-line writeback
// followed by a 256-bit line fill, then the request is re-evaluated as a hit.
module l1_cache_responder #(
    parameter int S_INDEX = 3,
    parameter int LINE_W  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [3:0]        mem_byte_enable,
    input  logic [31:0]       mem_address,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam int SETS  = 1 << S_INDEX;
    localparam int TAG_W = 32 - 5 - S_INDEX;
    localparam int WORDS = LINE_W / 32;

    typedef logic [WORDS-1:0][31:0] line_t;
    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t             state;
    logic [SETS-1:0]    valid_q;
    logic [SETS-1:0]    dirty_q;
    logic [TAG_W-1:0]   tag_q  [SETS];
    line_t              line_q [SETS];
    // Line address of the request that missed; fill targets this, not the
    // live CPU address, so a dropped request still completes coherently.
    logic [31:5]        miss_line_q;

    logic [S_INDEX-1:0] idx;
    logic [2:0]         word;
    logic [TAG_W-1:0]   req_tag;
    logic [S_INDEX-1:0] fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic               req;
    logic               hit;
    logic               hit_now;
    logic               wr_hit;
    logic [31:0]        merged;
    logic               unused_ok;

    assign idx      = mem_address[S_INDEX+4:5];
    assign word     = mem_address[4:2];
    assign req_tag  = mem_address[31:S_INDEX+5];
    assign fill_idx = miss_line_q[S_INDEX+4:5];
    assign fill_tag = miss_line_q[31:S_INDEX+5];
    assign req      = mem_read | mem_write;
    assign hit      = valid_q[idx] && (tag_q[idx] == req_tag);
    // Reset forces IDLE and clears valid, so no hit (and no output) in reset.
    assign hit_now  = (state == IDLE) && req && hit;
    // Write wins over read; an all-zero byte enable still acks but changes nothing.
    assign wr_hit   = hit_now && mem_write && (mem_byte_enable != 4'b0000);

    assign mem_resp  = hit_now;
    assign mem_rdata = hit_now ? line_q[idx][word] : 32'h0;
    assign unused_ok = &{1'b0, mem_address[1:0]};

    // Byte-lane merge of CPU write data into the addressed word.
    always_comb begin
        merged = line_q[idx][word];
        for (int b = 0; b < 4; b++) begin
            if (mem_byte_enable[b]) merged[b*8 +: 8] = mem_wdata[b*8 +: 8];
        end
    end

    // Miss FSM with registered pmem outputs; async reset drops them at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            miss_line_q  <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && !hit) begin
                        miss_line_q <= mem_address[31:5];
                        if (valid_q[idx] && dirty_q[idx]) begin
                            state        <= WRITEBACK;
                            pmem_write   <= 1'b1;
                            pmem_address <= {tag_q[idx], idx, 5'b0};
                            pmem_wdata   <= line_q[idx];
                        end else begin
                            state        <= ALLOCATE;
                            pmem_read    <= 1'b1;
                            pmem_address <= {mem_address[31:5], 5'b0};
                        end
                    end else if (wr_hit) begin
                        dirty_q[idx] <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        state             <= ALLOCATE;
                        dirty_q[fill_idx] <= 1'b0;
                        pmem_write        <= 1'b0;
                        pmem_wdata        <= '0;
                        pmem_read         <= 1'b1;
                        pmem_address      <= {miss_line_q, 5'b0};
                    end
                end
                ALLOCATE: begin
                    if (pmem_resp) begin
                        state             <= IDLE;
                        valid_q[fill_idx] <= 1'b1;
                        dirty_q[fill_idx] <= 1'b0;
                        pmem_read         <= 1'b0;
                        pmem_address      <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data arrays: line fill on pmem_resp, byte merge on write hit.
    always_ff @(posedge clk) begin
        if (state == ALLOCATE && pmem_resp) begin
            line_q[fill_idx] <= pmem_rdata;
            tag_q[fill_idx]  <= fill_tag;
        end else if (wr_hit) begin
            line_q[idx][word] <= merged;
        end
    end

endmodule

// File: tb/tb_l1_cache_responder.sv
// Directed bench for l1_cache_responder: reset, cold miss/fill, byte-enable
// write hits, dirty eviction, back-to-back reads, reset mid-fill, dropped request.
module tb_l1_cache_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_read, mem_write;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_address, mem_wdata, mem_rdata;
    logic         mem_resp;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0][31:0] l1, l1_mod, l2;

    always #5 clk = ~clk;

    l1_cache_responder #(.S_INDEX(3), .LINE_W(256)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
        mem_read        = rd;
        mem_write       = wr;
        mem_address     = a;
        mem_byte_enable = be;
        mem_wdata       = wd;
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            l1[k] = 32'hA000_0000 + k;
            l2[k] = 32'hB000_0000 + k;
        end
        l1[1]     = 32'hDEAD_BEEF;
        l1_mod    = l1;
        l1_mod[1] = 32'hDE22_BE44;
        l1_mod[3] = 32'hCAFE_F00D;

        // Reset with arbitrary inputs driven
        rst        = 1'b0;
        cpu(1'b1, 1'b1, 32'h44, 4'hF, 32'h1234_5678);
        pmem_resp  = 1'b1;
        pmem_rdata = {8{32'h5A5A_5A5A}};
        repeat (3) step();
        chk("rst_resp",  mem_resp, 0);
        chk("rst_rdata", mem_rdata, 0);
        chk("rst_pread", pmem_read, 0);
        chk("rst_pwrite", pmem_write, 0);
        chk("rst_paddr", pmem_address, 0);
        chk("rst_pwdata", pmem_wdata, 0);
        cpu(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        pmem_resp = 1'b0;
        rst       = 1'b1;

        // First read after reset misses
        step();
        cpu(1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
        #1 chk("cold_resp0", mem_resp, 0);
        step();
        chk("cold_pread", pmem_read, 1);
        chk("cold_paddr", pmem_address, 32'h40);

        // Reset mid-fill: pmem_read drops asynchronously, fill is discarded
        rst = 1'b0;
        #1 chk("midrst_pread", pmem_read, 0);
        chk("midrst_paddr", pmem_address, 0);
        pmem_resp  = 1'b1;
        pmem_rdata = l1;
        step();
        step();
        pmem_resp = 1'b0;
        rst       = 1'b1;
        cpu(1'b1, 1'b0, 32'h44, 4'h0, 32'h0);
        #1 chk("postrst_miss", mem_resp, 0);

        // Cold miss with 5-cycle fill
        step();
        chk("fill_pread", pmem_read, 1);
        chk("fill_paddr", pmem_address, 32'h40);
        repeat (4) step();
        chk("fill_wait_resp", mem_resp, 0);
        chk("fill_wait_pread", pmem_read, 1);
        pmem_resp  = 1'b1;
        pmem_rdata = l1;
        step();
        pmem_resp = 1'b0;
        #1 chk("fill_resp", mem_resp, 1);
        chk("fill_rdata", mem_rdata, 32'hDEAD_BEEF);
        chk("fill_pread_off", pmem_read, 0);
        mem_address = 32'h48;
        #1 chk("hit48_resp", mem_resp, 1);
        chk("hit48_rdata", mem_rdata, 32'hA000_0002);

        // Write hits: byte enables, zero enables, read+write as write
        step();
        cpu(1'b0, 1'b1, 32'h44, 4'b0101, 32'h1122_3344);
        #1 chk("wr_resp", mem_resp, 1);
        chk("wr_preword", mem_rdata, 32'hDEAD_BEEF);
        step();
        cpu(1'b0, 1'b1, 32'h48, 4'b0000, 32'hFFFF_FFFF);
        #1 chk("wr_be0_resp", mem_resp, 1);
        step();
        cpu(1'b1, 1'b1, 32'h4C, 4'b1111, 32'hCAFE_F00D);
        #1 chk("rdwr_resp", mem_resp, 1);
        step();
        cpu(1'b1, 1'b0, 32'h44, 4'h0, 32'h0);
        #1 chk("rd_merged", mem_rdata, 32'hDE22_BE44);
        mem_address = 32'h48;
        #1 chk("rd_be0", mem_rdata, 32'hA000_0002);
        mem_address = 32'h4C;
        #1 chk("rd_rdwr", mem_rdata, 32'hCAFE_F00D);

        // Dirty conflict eviction of set 2
        mem_address = 32'h140;
        #1 chk("evict_resp0", mem_resp, 0);
        step();
        chk("wb_pwrite", pmem_write, 1);
        chk("wb_pread", pmem_read, 0);
        chk("wb_paddr", pmem_address, 32'h40);
        chk("wb_pwdata", pmem_wdata, l1_mod);
        step();
        step();
        chk("wb_hold_pwrite", pmem_write, 1);
        chk("wb_hold_pwdata", pmem_wdata, l1_mod);
        chk("wb_hold_resp", mem_resp, 0);
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        #1 chk("alloc_pwrite", pmem_write, 0);
        chk("alloc_pread", pmem_read, 1);
        chk("alloc_paddr", pmem_address, 32'h140);
        pmem_resp  = 1'b1;
        pmem_rdata = l2;
        step();
        pmem_resp = 1'b0;
        #1 chk("evict_resp", mem_resp, 1);
        chk("evict_rdata", mem_rdata, 32'hB000_0000);

        // Back-to-back reads, one per cycle
        step();
        mem_address = 32'h144;
        #1 chk("ic_resp1", mem_resp, 1);
        chk("ic_rdata1", mem_rdata, 32'hB000_0001);
        step();
        mem_address = 32'h148;
        #1 chk("ic_resp2", mem_resp, 1);
        chk("ic_rdata2", mem_rdata, 32'hB000_0002);
        step();
        mem_address = 32'h140;
        #1 chk("ic_resp3", mem_resp, 1);
        chk("ic_rdata3", mem_rdata, 32'hB000_0000);

        // Clean line is replaced without writeback; request dropped mid-fill
        step();
        mem_address = 32'h40;
        #1 chk("clean_resp0", mem_resp, 0);
        step();
        chk("clean_pwrite", pmem_write, 0);
        chk("clean_pread", pmem_read, 1);
        chk("clean_paddr", pmem_address, 32'h40);
        mem_read   = 1'b0;
        pmem_resp  = 1'b1;
        pmem_rdata = l1;
        step();
        pmem_resp = 1'b0;
        #1 chk("drop_resp", mem_resp, 0);
        chk("drop_pread", pmem_read, 0);

        // Stray pmem_resp in IDLE is ignored
        pmem_resp = 1'b1;
        step();
        step();
        pmem_resp = 1'b0;
        #1 chk("stray_pread", pmem_read, 0);
        chk("stray_pwrite", pmem_write, 0);
        cpu(1'b1, 1'b0, 32'h44, 4'h0, 32'h0);
        #1 chk("refill_resp", mem_resp, 1);
        chk("refill_rdata", mem_rdata, 32'hDEAD_BEEF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
